seg_serial_display: RTL and testbench

//  Parametrised serial driver for a chain of DIGITS 7-segment digits behind shift-register/latch ICs.

---
 rtl/seg_serial_display_if.sv | 25 ++
 rtl/seg_serial_display.sv | 189 ++++++++++++++++++
 tb/tb_seg_serial_display.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/seg_serial_display_if.sv
// Control/data bundle between the display data mux and the serial segment driver.
interface seg_serial_display_if #(
  parameter int unsigned DIGITS = 8
);
  logic                  start;
  logic [1:0]            mode;
  logic                  flash;
  logic [4*DIGITS-1:0]   hexs;
  logic [DIGITS-1:0]     points;
  logic [DIGITS-1:0]     les;
  logic [8*DIGITS-1:0]   raw_seg;
  logic                  busy;
  logic                  done;
  logic [8*DIGITS-1:0]   seg64;

  modport master (
    output start, mode, flash, hexs, points, les, raw_seg,
    input  busy, done, seg64
  );

  modport slave (
    input  start, mode, flash, hexs, points, les, raw_seg,
    output busy, done, seg64
  );
endinterface

// File: rtl/seg_serial_display.sv
// Serial driver for a chain of 7-segment digits behind shift-register/latch ICs.
// Builds an active-low frame, then issues clear pulse -> clocked bits -> latch pulse.
module seg_serial_display #(
  parameter int unsigned DIGITS     = 8,
  parameter int unsigned CLK_DIV    = 2,
  parameter int unsigned FLASH_BITS = 24,
  parameter bit          DIR        = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  seg_serial_display_if.slave bus,
  output logic              seg_clk,
  output logic              seg_sout,
  output logic              SEG_PEN,
  output logic              seg_clrn
);

  localparam int unsigned NBITS = 8 * DIGITS;
  localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned BIT_W = $clog2(NBITS);

  typedef enum logic [2:0] {IDLE, CLEAR, SHIFT, LATCH, DONE} state_t;

  state_t             state_q, state_d;
  logic [DIV_W-1:0]   div_q, div_d;
  logic [BIT_W-1:0]   bit_q, bit_d;
  logic [NBITS-1:0]   shreg_q, shreg_d;
  logic [NBITS-1:0]   seg64_q, seg64_d;
  logic [NBITS-1:0]   frame;
  logic [NBITS-1:0]   shreg_next;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               sclk_q, sclk_d;
  logic               sout_q, sout_d;
  logic               pen_q, pen_d;
  logic               clrn_q, clrn_d;
  logic [FLASH_BITS-1:0] cnt_q;

  function automatic logic [6:0] hex7(input logic [3:0] h);
    logic [6:0] s;
    s = 7'h00;
    unique case (h)
      4'h0: s = 7'h3F;  4'h1: s = 7'h06;  4'h2: s = 7'h5B;  4'h3: s = 7'h4F;
      4'h4: s = 7'h66;  4'h5: s = 7'h6D;  4'h6: s = 7'h7D;  4'h7: s = 7'h07;
      4'h8: s = 7'h7F;  4'h9: s = 7'h6F;  4'hA: s = 7'h77;  4'hB: s = 7'h7C;
      4'hC: s = 7'h39;  4'hD: s = 7'h5E;  4'hE: s = 7'h79;  4'hF: s = 7'h71;
      default: s = 7'h00;
    endcase
    return s;
  endfunction

  function automatic logic first_bit(input logic [NBITS-1:0] v);
    return DIR ? v[NBITS-1] : v[0];
  endfunction

  // Active-high lit pattern per digit, inverted into the active-low frame
  always_comb begin
    logic [7:0] lit;
    frame = '1;
    lit   = 8'h00;
    for (int i = 0; i < int'(DIGITS); i++) begin
      unique case (bus.mode)
        2'd0:    lit = {bus.points[i], hex7(bus.hexs[4*i +: 4])};
        2'd1:    lit = bus.raw_seg[8*i +: 8];
        2'd2:    lit = 8'h00;
        default: lit = 8'hFF;
      endcase
      if (!bus.mode[1] && bus.flash && bus.les[i] && cnt_q[FLASH_BITS-1])
        lit = 8'h00;
      frame[8*i +: 8] = ~lit;
    end
  end

  assign shreg_next = DIR ? {shreg_q[NBITS-2:0], 1'b0} : {1'b0, shreg_q[NBITS-1:1]};

  // Next-state and next-output logic
  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    seg64_d = seg64_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    sclk_d  = sclk_q;
    sout_d  = sout_q;
    pen_d   = pen_q;
    clrn_d  = 1'b1;

    unique case (state_q)
      IDLE: begin
        busy_d = 1'b0;
        sclk_d = 1'b0;
        pen_d  = 1'b0;
        if (bus.start) begin
          state_d = CLEAR;
          shreg_d = frame;
          seg64_d = frame;
          clrn_d  = 1'b0;
          busy_d  = 1'b1;
        end
      end
      CLEAR: begin
        state_d = SHIFT;
        sclk_d  = 1'b0;
        sout_d  = first_bit(shreg_q);
        div_d   = '0;
        bit_d   = '0;
      end
      SHIFT: begin
        if (div_q == DIV_W'(CLK_DIV - 1)) begin
          div_d = '0;
          if (!sclk_q) begin
            sclk_d = 1'b1;
          end else begin
            sclk_d = 1'b0;
            if (bit_q == BIT_W'(NBITS - 1)) begin
              state_d = LATCH;
              pen_d   = 1'b1;
            end else begin
              bit_d   = bit_q + BIT_W'(1);
              shreg_d = shreg_next;
              sout_d  = first_bit(shreg_next);
            end
          end
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      LATCH: begin
        if (div_q == DIV_W'(CLK_DIV - 1)) begin
          div_d   = '0;
          state_d = DONE;
          pen_d   = 1'b0;
          done_d  = 1'b1;
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      div_q   <= '0;
      bit_q   <= '0;
      shreg_q <= '1;
      seg64_q <= '1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      sclk_q  <= 1'b0;
      sout_q  <= 1'b0;
      pen_q   <= 1'b0;
      clrn_q  <= 1'b1;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      seg64_q <= seg64_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      sclk_q  <= sclk_d;
      sout_q  <= sout_d;
      pen_q   <= pen_d;
      clrn_q  <= clrn_d;
      cnt_q   <= cnt_q + FLASH_BITS'(1);
    end
  end

  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
  assign bus.seg64 = seg64_q;
  assign seg_clk   = sclk_q;
  assign seg_sout  = sout_q;
  assign SEG_PEN   = pen_q;
  assign seg_clrn  = clrn_q;

endmodule

// File: tb/tb_seg_serial_display.sv
// Bench for seg_serial_display: DIGITS=8, CLK_DIV=1, FLASH_BITS=4, MSB first.
module tb_seg_serial_display;

  logic clk = 1'b0;
  logic rst;
  logic seg_clk, seg_sout, SEG_PEN, seg_clrn;

  seg_serial_display_if #(.DIGITS(8)) bus ();

  seg_serial_display #(.DIGITS(8), .CLK_DIV(1), .FLASH_BITS(4), .DIR(1'b1)) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .seg_clk(seg_clk), .seg_sout(seg_sout), .SEG_PEN(SEG_PEN), .seg_clrn(seg_clrn)
  );

  always #5 clk = ~clk;

  int n_asserts = 0;
  int n_fail    = 0;

  logic [6:0] hex_tbl [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  // Cycles since the last reset edge: the value the blink counter holds right now
  int since_rst = 0;
  always @(posedge clk) since_rst <= rst ? 0 : since_rst + 1;

  // Observer of the pin-level protocol, sampled on the falling clk edge
  logic        prev_sclk = 1'b0, prev_busy = 1'b0;
  logic [63:0] rx = '0;
  int rises = 0, pen_cyc = 0, done_cyc = 0, busy_cyc = 0, clrn_cyc = 0;
  int cyc = 0, accepts = 0, last_acc = 0, period = 0;
  always @(negedge clk) begin
    prev_sclk <= seg_clk;
    prev_busy <= bus.busy;
    cyc       <= cyc + 1;
    if (seg_clk === 1'b1 && prev_sclk === 1'b0) begin
      rises <= rises + 1;
      rx    <= {rx[62:0], seg_sout};
    end
    if (SEG_PEN === 1'b1)   pen_cyc  <= pen_cyc + 1;
    if (bus.done === 1'b1)  done_cyc <= done_cyc + 1;
    if (bus.busy === 1'b1)  busy_cyc <= busy_cyc + 1;
    if (seg_clrn === 1'b0)  clrn_cyc <= clrn_cyc + 1;
    if (bus.busy === 1'b1 && prev_busy === 1'b0) begin
      accepts  <= accepts + 1;
      last_acc <= cyc;
      period   <= cyc - last_acc;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Frame from the display rules: byte i = inverted {dp, gfedcba} of digit i
  function automatic logic [63:0] ref_frame(input logic [1:0] m, input logic fl,
      input logic [31:0] h, input logic [7:0] p, input logic [7:0] l,
      input logic [63:0] r, input logic phase);
    logic [63:0] f;
    logic [7:0]  b;
    logic [3:0]  nib;
    for (int i = 0; i < 8; i++) begin
      nib = h[4*i +: 4];
      case (m)
        2'd0:    b = ~{p[i], hex_tbl[nib]};
        2'd1:    b = ~r[8*i +: 8];
        2'd2:    b = 8'hFF;
        default: b = 8'h00;
      endcase
      if (m <= 2'd1 && fl && l[i] && phase) b = 8'hFF;
      f[8*i +: 8] = b;
    end
    return f;
  endfunction

  task automatic set_inputs(input logic [1:0] m, input logic fl, input logic [31:0] h,
      input logic [7:0] p, input logic [7:0] l, input logic [63:0] r);
    bus.mode = m; bus.flash = fl; bus.hexs = h; bus.points = p; bus.les = l; bus.raw_seg = r;
  endtask

  task automatic scramble();
    set_inputs(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), $urandom,
               8'($urandom), 8'($urandom), {$urandom, $urandom});
  endtask

  task automatic wait_idle(input string tag);
    int guard = 0;
    while (bus.busy !== 1'b0 && guard < 600) begin
      @(negedge clk);
      guard++;
    end
    chk({tag, "_timeout"}, 64'(guard < 600), 64'd1);
    @(negedge clk);
  endtask

  // One full transfer; want_phase selects the blink phase at accept (-1 = any)
  task automatic run_frame(input string tag, input logic [1:0] m, input logic fl,
      input logic [31:0] h, input logic [7:0] p, input logic [7:0] l, input logic [63:0] r,
      input int want_phase, input bit repulse);
    logic [63:0] exp;
    int r0, p0, d0, b0, c0;
    @(negedge clk);
    for (int g = 0; g < 16 && want_phase >= 0 && ((since_rst % 16) >= 8) != (want_phase == 1); g++)
      @(negedge clk);
    set_inputs(m, fl, h, p, l, r);
    bus.start = 1'b1;
    exp = ref_frame(m, fl, h, p, l, r, (since_rst % 16) >= 8);
    r0 = rises; p0 = pen_cyc; d0 = done_cyc; b0 = busy_cyc; c0 = clrn_cyc;
    @(negedge clk);
    bus.start = 1'b0;
    scramble();
    if (repulse) begin
      repeat (40) @(negedge clk);
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
    end
    wait_idle(tag);
    chk({tag, "_seg64"}, bus.seg64, exp);
    chk({tag, "_serial"}, rx, exp);
    chk({tag, "_rises"}, 64'(rises - r0), 64'd64);
    chk({tag, "_pen"}, 64'(pen_cyc - p0), 64'd1);
    chk({tag, "_done"}, 64'(done_cyc - d0), 64'd1);
    chk({tag, "_busy"}, 64'(busy_cyc - b0), 64'd131);
    chk({tag, "_clrn"}, 64'(clrn_cyc - c0), 64'd1);
    chk({tag, "_idle_pins"}, {61'd0, seg_clk, SEG_PEN, seg_clrn}, 64'd1);
  endtask

  initial begin
    int d0, a0, guard;
    logic [63:0] exp;
    rst = 1'b1;
    bus.start = 1'b1;
    scramble();
    repeat (2) @(negedge clk);
    chk("rst_seg64", bus.seg64, '1);
    chk("rst_pins", {58'd0, seg_clk, seg_sout, SEG_PEN, seg_clrn, bus.busy, bus.done},
        64'b00_0100);
    rst = 1'b0;
    bus.start = 1'b0;

    run_frame("hex0", 2'd0, 1'b0, 32'h7654_3210, 8'h00, 8'h00, '0, -1, 1'b0);
    chk("hex0_const", bus.seg64, 64'hF882_9299_B0A4_F9C0);
    run_frame("pts", 2'd0, 1'b0, 32'h7654_3210, 8'h01, 8'h00, '0, -1, 1'b0);
    chk("pts_const", bus.seg64, 64'hF882_9299_B0A4_F940);
    run_frame("lamp", 2'd3, 1'b1, $urandom, 8'($urandom), 8'hFF, '0, -1, 1'b0);
    chk("lamp_const", bus.seg64, 64'h0);
    run_frame("off", 2'd2, 1'b1, $urandom, 8'($urandom), 8'hFF, '0, -1, 1'b0);
    chk("off_const", bus.seg64, '1);
    run_frame("raw", 2'd1, 1'b0, $urandom, 8'hFF, 8'h00, 64'h3F, -1, 1'b0);
    chk("raw_const", bus.seg64, 64'hFFFF_FFFF_FFFF_FFC0);
    run_frame("blink_on", 2'd0, 1'b1, 32'h7654_3210, 8'h00, 8'h80, '0, 1, 1'b0);
    chk("blink_on_const", bus.seg64, 64'hFF82_9299_B0A4_F9C0);
    run_frame("blink_off", 2'd0, 1'b1, 32'h7654_3210, 8'h00, 8'h80, '0, 0, 1'b0);
    chk("blink_off_const", bus.seg64, 64'hF882_9299_B0A4_F9C0);

    for (int k = 0; k < 8; k++)
      run_frame($sformatf("rand%0d", k), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                $urandom, 8'($urandom), 8'($urandom), {$urandom, $urandom}, -1, 1'b0);

    run_frame("repulse", 2'd0, 1'b0, $urandom, 8'($urandom), 8'h00, '0, -1, 1'b1);

    // start held high: back-to-back frames
    @(negedge clk);
    set_inputs(2'd0, 1'b0, 32'hDEAD_BEEF, 8'hA5, 8'h00, '0);
    exp = ref_frame(2'd0, 1'b0, 32'hDEAD_BEEF, 8'hA5, 8'h00, '0, 1'b0);
    bus.start = 1'b1;
    a0 = accepts; d0 = done_cyc; guard = 0;
    while (accepts < a0 + 2 && guard < 600) begin
      @(negedge clk);
      guard++;
    end
    bus.start = 1'b0;
    chk("b2b_timeout", 64'(guard < 600), 64'd1);
    chk("b2b_period", 64'(period), 64'd132);
    wait_idle("b2b");
    chk("b2b_done", 64'(done_cyc - d0), 64'd2);
    chk("b2b_seg64", bus.seg64, exp);
    chk("b2b_serial", rx, exp);

    // reset in the middle of a shift
    @(negedge clk);
    set_inputs(2'd0, 1'b0, 32'h1234_5678, 8'h00, 8'h00, '0);
    bus.start = 1'b1;
    d0 = done_cyc;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (30) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_pins", {59'd0, seg_clk, SEG_PEN, seg_clrn, bus.busy, bus.done}, 64'b00100);
    chk("mid_rst_seg64", bus.seg64, '1);
    repeat (150) @(negedge clk);
    chk("mid_rst_nodone", 64'(done_cyc - d0), 64'd0);
    run_frame("after_rst", 2'd0, 1'b0, 32'hFEDC_BA98, 8'h5A, 8'h00, '0, -1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
